ahb_arbiter: RTL and testbench

- Round-robin AHB bus arbiter.
- Shares the single AHB slave path (SRAM and the other slaves behind the decoder) between up to NUM_MASTERS requesters.
- Drives the per-master grants, the HMASTER select for the address/data muxes, and HMASTLOCK.
- Supports locked transfers, a bounded hold time per owner, and parking on a default master when nobody requests.

---
 rtl/ahb_arbiter_if.sv | 26 ++
 rtl/ahb_arbiter.sv | 91 +++++++++
 tb/tb_ahb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bundle: per-master request/lock in, one-hot grant and
// address-phase owner out, plus the muxed HTRANS/HREADY the arbiter watches.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    // Arbiter side
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );

    // Requester / bus-fabric side
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with locked transfers, bounded hold per owner and
// parking on DEFAULT_MASTER. All decisions are taken only on HREADY=1 cycles.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16,
    parameter int MW             = $clog2(NUM_MASTERS)
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {PARK, OWNED, LOCKED} state_t;

    localparam logic [MW-1:0] DEF_IDX  = MW'(DEFAULT_MASTER);
    localparam logic [7:0]    HOLD_MAX = 8'(MAX_HOLD);

    state_t                 state, state_nxt;
    logic [MW-1:0]          own_idx;     // index of the currently granted master
    logic [MW-1:0]          win_idx;
    logic [MW-1:0]          rr_idx;
    logic [MW-1:0]          jm;
    logic [7:0]             hold_cnt;
    logic [NUM_MASTERS-1:0] own_mask;
    logic                   own_req, own_lock, any_req, others_req, rearb, found;
    int                     j;

    // Next owner: lock keeps the owner, no requests parks, otherwise the
    // round-robin search from owner+1 runs whenever a handover is due.
    always_comb begin
        own_mask   = NUM_MASTERS'(1) << own_idx;
        own_req    = bus.HBUSREQ[own_idx];
        own_lock   = bus.HLOCK[own_idx];
        any_req    = |bus.HBUSREQ;
        others_req = |(bus.HBUSREQ & ~own_mask);
        rearb      = (state == PARK) || !own_req ||
                     ((bus.HTRANS == 2'b00) && others_req) ||
                     ((hold_cnt == HOLD_MAX) && others_req);

        // Search ends at the owner itself, so a lone requesting owner keeps it.
        rr_idx = DEF_IDX;
        found  = 1'b0;
        j      = 0;
        jm     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            j  = (int'(own_idx) + k) % NUM_MASTERS;
            jm = MW'(j);
            if (!found && bus.HBUSREQ[jm]) begin
                rr_idx = jm;
                found  = 1'b1;
            end
        end

        if (own_req && own_lock) begin
            win_idx   = own_idx;
            state_nxt = LOCKED;
        end else if (!any_req) begin
            win_idx   = DEF_IDX;
            state_nxt = PARK;
        end else if (rearb) begin
            win_idx   = rr_idx;
            state_nxt = OWNED;
        end else begin
            win_idx   = own_idx;
            state_nxt = OWNED;
        end
    end

    // Arbitration FSM with registered grant/owner outputs, frozen while HREADY=0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= PARK;
            own_idx       <= DEF_IDX;
            bus.HGRANT    <= NUM_MASTERS'(1) << DEF_IDX;
            bus.HMASTER   <= DEF_IDX;
            bus.HMASTLOCK <= 1'b0;
            hold_cnt      <= '0;
        end else if (bus.HREADY) begin
            state         <= state_nxt;
            // Address phase moves to whoever held the grant during this transfer.
            bus.HMASTER   <= own_idx;
            bus.HMASTLOCK <= own_lock;
            own_idx       <= win_idx;
            bus.HGRANT    <= NUM_MASTERS'(1) << win_idx;
            if (win_idx != own_idx)
                hold_cnt <= '0;
            else if (bus.HTRANS[1] && hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Randomized + directed bench for ahb_arbiter against a behavioural model.
module tb_ahb_arbiter;
    localparam int N    = 4;
    localparam int DEF  = 0;
    localparam int MAXH = 4;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   checks = 0;
    int   fails  = 0;

    // model state
    int m_own, m_mast, m_hold;
    bit m_ml, m_park;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MAX_HOLD(MAXH)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = DEF; m_mast = DEF; m_hold = 0; m_ml = 1'b0; m_park = 1'b1;
    endtask

    // One arbitration edge computed straight from the rules on current inputs.
    task automatic model_edge();
        logic [N-1:0] rq, lk;
        logic [1:0]   tr;
        int           nxt, others;
        bit           own_rq, own_lk;
        rq = bus.HBUSREQ; lk = bus.HLOCK; tr = bus.HTRANS;
        if (!bus.HREADY) return;
        own_rq = rq[m_own[1:0]];
        own_lk = lk[m_own[1:0]];
        others = $countones(rq) - (own_rq ? 1 : 0);
        nxt = m_own;
        if (own_rq && own_lk)
            nxt = m_own;
        else if (rq == '0)
            nxt = DEF;
        else if (m_park || !own_rq || (tr == 2'b00 && others > 0) ||
                 (m_hold == MAXH && others > 0)) begin
            for (int d = 1; d <= N; d++) begin
                int c;
                c = (m_own + d) % N;
                if (rq[c[1:0]]) begin
                    nxt = c;
                    break;
                end
            end
        end
        m_mast = m_own;
        m_ml   = own_lk;
        if (nxt != m_own) m_hold = 0;
        else if (tr[1] && m_hold < MAXH) m_hold = m_hold + 1;
        m_park = (rq == '0);
        m_own  = nxt;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_gnt"},  32'(bus.HGRANT),    32'(1 << m_own));
        chk({tag, "_mst"},  32'(bus.HMASTER),   32'(m_mast));
        chk({tag, "_lock"}, 32'(bus.HMASTLOCK), 32'(m_ml));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge HCLK);
        #1;
        cmp_all(tag);
    endtask

    task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] lk,
                         input logic [1:0] tr, input logic rdy);
        bus.HBUSREQ = rq; bus.HLOCK = lk; bus.HTRANS = tr; bus.HREADY = rdy;
    endtask

    // Async reset pulse placed between edges; outputs must return at once.
    task automatic async_reset(input string tag);
        #1 HRESETn = 1'b0;
        #1;
        chk({tag, "_gnt"},  32'(bus.HGRANT),    32'h1);
        chk({tag, "_mst"},  32'(bus.HMASTER),   32'h0);
        chk({tag, "_lock"}, 32'(bus.HMASTLOCK), 32'h0);
        model_reset();
        #1 HRESETn = 1'b1;
    endtask

    initial begin
        bit saw1, saw3;
        HRESETn = 1'b0;
        drive('0, '0, 2'b00, 1'b1);
        model_reset();
        #7;
        cmp_all("rst");
        HRESETn = 1'b1;

        // idle parking
        for (int i = 0; i < 5; i++) begin
            step("idle");
            chk("idle_const", 32'(bus.HGRANT), 32'h1);
        end

        // M2 grabs the bus, then reset mid-stream with HGRANT=0100
        drive(4'b0100, '0, 2'b10, 1'b1);
        step("getm2");
        chk("getm2_const", 32'(bus.HGRANT), 32'h4);
        async_reset("midrst");

        // round robin between M1 and M3
        saw1 = 0; saw3 = 0;
        drive(4'b1010, '0, 2'b10, 1'b1);
        for (int i = 0; i < 24; i++) begin
            bus.HTRANS = (i % 2 == 0) ? 2'b10 : 2'b11;
            step("rr");
            if (bus.HGRANT == 4'b0010) saw1 = 1;
            if (bus.HGRANT == 4'b1000) saw3 = 1;
        end
        chk("rr_saw_m1", 32'(saw1), 32'h1);
        chk("rr_saw_m3", 32'(saw3), 32'h1);

        // locked M2 against requesting M0
        drive('0, '0, 2'b00, 1'b1);
        step("lk_idle");
        drive(4'b0101, 4'b0100, 2'b10, 1'b1);
        step("lk_grant");
        chk("lk_grant_const", 32'(bus.HGRANT), 32'h4);
        for (int i = 0; i < 20; i++) begin
            step("lk_hold");
            chk("lk_hold_const", 32'(bus.HGRANT), 32'h4);
            chk("lk_ml_const", 32'(bus.HMASTLOCK), 32'h1);
        end
        bus.HLOCK = '0;
        step("lk_drop");
        chk("lk_drop_const", 32'(bus.HGRANT), 32'h1);
        chk("lk_drop_ml", 32'(bus.HMASTLOCK), 32'h0);

        // HREADY stall with hold counter saturated
        drive(4'b0001, '0, 2'b10, 1'b1);
        for (int i = 0; i < 6; i++) step("st_own");
        drive(4'b0011, '0, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_const", 32'(bus.HGRANT), 32'h1);
        end
        bus.HREADY = 1'b1;
        step("st_go");
        chk("st_go_const", 32'(bus.HGRANT), 32'h2);

        // owner M3 drops as M0/M2 raise: wrap to M0, then park
        drive(4'b1000, '0, 2'b10, 1'b1);
        step("w_m3a");
        step("w_m3b");
        chk("w_m3_const", 32'(bus.HGRANT), 32'h8);
        drive(4'b0101, '0, 2'b10, 1'b1);
        step("wrap");
        chk("wrap_const", 32'(bus.HGRANT), 32'h1);
        drive(4'b0000, '0, 2'b00, 1'b1);
        step("park");
        bus.HBUSREQ = 4'b0110;
        step("park_rr");
        chk("park_rr_const", 32'(bus.HGRANT), 32'h2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rq, lk;
            rq = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, 15));
            lk = ($urandom_range(0, 2) == 0) ? (rq & N'($urandom_range(0, 15))) : '0;
            drive(rq, lk, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            step("rnd");
            chk("rnd_onehot", 32'($countones(bus.HGRANT)), 32'h1);
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
